// File: rtl/test_burst_gen_if.sv
// Bus between the UART-side environment and test_burst_gen.
//
// Handshake semantics (single place they are described):
//   newRxData : one-cycle strobe qualifying idata; there is no back-pressure,
//               a strobe the block is not ready for (any state but IDLE) is lost.
//   txBusy    : level from the transmitter; a word is issued only in a cycle
//               where txBusy is low, so txBusy acts as an inverted ready.
//   oe        : one-cycle strobe qualifying odata; odata is held between strobes.
//   done      : one-cycle pulse the cycle after the last oe of a burst.
//   busy      : level, high whenever the generator is not in IDLE.
interface test_burst_gen_if #(
  parameter int DATA_W = 8
);
  logic [7:0]        idata;
  logic              newRxData;
  logic              txBusy;
  logic [DATA_W-1:0] testdata;
  logic [DATA_W-1:0] odata;
  logic              oe;
  logic              busy;
  logic              done;

  // Environment side: supplies commands, transmitter status and sample data.
  modport master (
    output idata, newRxData, txBusy, testdata,
    input  odata, oe, busy, done
  );

  // Generator side.
  modport slave (
    input  idata, newRxData, txBusy, testdata,
    output odata, oe, busy, done
  );
endinterface

// File: rtl/test_burst_gen.sv
// UART test-pattern burst generator. A command byte picks a pattern mode
// (idata[7:6]) and a burst length (idata[5:0] + 1). Each word is preceded by a
// DLY_CYCLES gap and waits for the transmitter to be idle before it is issued.
module test_burst_gen #(
  parameter int DATA_W     = 8,
  parameter int DLY_W      = 32,
  parameter int DLY_CYCLES = 100000000
) (
  input  logic                  clk,
  input  logic                  rst,
  test_burst_gen_if.slave       bus,
  output logic [2:0]            state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_GAP     = 3'd2,
    S_WAIT_TX = 3'd3,
    S_EMIT    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [DATA_W-1:0] ALT0     = {(DATA_W/2){2'b01}};
  localparam logic [DLY_W-1:0]  GAP_LAST = DLY_W'(DLY_CYCLES - 1);

  state_t            state_q, state_d;
  logic              rx_valid_q, rx_valid_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [1:0]        mode_q, mode_d;
  logic [6:0]        n_q, n_d;
  logic [6:0]        sent_q, sent_d;
  logic [DLY_W-1:0]  gap_q, gap_d;
  logic [DATA_W-1:0] pat_q, pat_d;
  logic              alt_q, alt_d;
  logic [DATA_W-1:0] odata_q, odata_d;
  logic              oe_q, oe_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] echo_word;
  logic [DATA_W-1:0] mode_word;

  // Command byte resized to the output width (zero-extend or truncate).
  generate
    if (DATA_W > 8) begin : g_echo_ext
      assign echo_word = {{(DATA_W-8){1'b0}}, cmd_q};
    end else if (DATA_W == 8) begin : g_echo_eq
      assign echo_word = cmd_q;
    end else begin : g_echo_trunc
      assign echo_word = cmd_q[DATA_W-1:0];
    end
  endgenerate

  // Word for the current mode; mode 0 samples testdata when the word is issued.
  always_comb begin
    mode_word = bus.testdata;
    case (mode_q)
      2'd0:    mode_word = bus.testdata;
      2'd1:    mode_word = pat_q;
      2'd2:    mode_word = echo_word;
      default: mode_word = alt_q ? ~ALT0 : ALT0;
    endcase
  end

  // Next-state and datapath updates; every register holds unless its state acts.
  always_comb begin
    state_d    = state_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    cmd_d      = cmd_q;
    mode_d     = mode_q;
    n_d        = n_q;
    sent_d     = sent_q;
    gap_d      = gap_q;
    pat_d      = pat_q;
    alt_d      = alt_q;
    odata_d    = odata_q;
    oe_d       = 1'b0;
    done_d     = 1'b0;

    // The receive strobe is captured only while idle; a strobe arriving in
    // any other state is dropped rather than queued.
    if (state_q == S_IDLE && !rx_valid_q && bus.newRxData) begin
      rx_valid_d = 1'b1;
      rx_data_d  = bus.idata;
    end

    case (state_q)
      S_IDLE: begin
        if (rx_valid_q) begin
          // Decode on the edge that enters LOAD.
          cmd_d   = rx_data_q;
          mode_d  = rx_data_q[7:6];
          n_d     = {1'b0, rx_data_q[5:0]} + 7'd1;
          sent_d  = '0;
          pat_d   = '0;
          alt_d   = 1'b0;
          gap_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        sent_d  = '0;
        pat_d   = '0;
        alt_d   = 1'b0;
        gap_d   = '0;
        state_d = S_GAP;
      end
      S_GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_LAST) begin
          state_d = S_WAIT_TX;
        end
      end
      S_WAIT_TX: begin
        if (!bus.txBusy) begin
          odata_d = mode_word;
          oe_d    = 1'b1;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        sent_d = sent_q + 7'd1;
        if ((sent_q + 7'd1) < n_q) begin
          gap_d   = '0;
          pat_d   = pat_q + 1'b1;
          alt_d   = ~alt_q;
          state_d = S_GAP;
        end else begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      cmd_q      <= '0;
      mode_q     <= '0;
      n_q        <= '0;
      sent_q     <= '0;
      gap_q      <= '0;
      pat_q      <= '0;
      alt_q      <= 1'b0;
      odata_q    <= '0;
      oe_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      cmd_q      <= cmd_d;
      mode_q     <= mode_d;
      n_q        <= n_d;
      sent_q     <= sent_d;
      gap_q      <= gap_d;
      pat_q      <= pat_d;
      alt_q      <= alt_d;
      odata_q    <= odata_d;
      oe_q       <= oe_d;
      done_q     <= done_d;
    end
  end

  assign bus.odata = odata_q;
  assign bus.oe    = oe_q;
  assign bus.done  = done_q;
  assign bus.busy  = (state_q != S_IDLE);
  assign state_o   = state_q;

endmodule

// File: doc/test_burst_gen.md
# test_burst_gen

Parametrised UART test-pattern burst generator. A received command byte selects a pattern mode and a burst length. The block then emits that many data words toward the UART transmitter, inserting a programmable gap before each word and honouring the transmitter's busy flag. It sits between the UART receiver (`idata`/`newRxData`) and the UART transmitter (`odata`/`oe`/`txBusy`), and it generalises the single-shot test generator to multi-word bursts, several pattern modes and arbitrary data width.

## Interface
- `DATA_W`, 8: width of `testdata` and `odata`; must be even and ≥ 2.
- `DLY_W`, 32: width of the gap counter.
- `DLY_CYCLES`, 100000000: clock cycles spent in GAP before each word; must be ≥ 1 and < 2^DLY_W.

Ports:
- `clk`  in  1  system clock; all state is updated on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `idata`  in  8  command byte from the UART receiver.
- `newRxData`  in  1  one-cycle strobe: `idata` is valid.
- `txBusy`  in  1  UART transmitter busy; words are issued only while it is low.
- `testdata`  in  DATA_W  external sample word used in mode 0.
- `odata`  out  DATA_W  word presented to the transmitter; registered.
- `oe`  out  1  one-cycle strobe: `odata` is valid; registered.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last word of a burst.

## Operation
- Command decode happens on the LOAD entry edge. `mode = idata[7:6]`. Burst length `N = idata[5:0] + 1`, range 1..64. The whole byte is latched as `cmd`.
- Modes:
  - 0: emit `testdata`, sampled at the WAIT_TX→EMIT edge.
  - 1: incrementing counter. Starts at 0 for each burst, +1 per emitted word, wraps modulo 2^DATA_W.
  - 2: echo `cmd`, zero-extended or truncated to DATA_W.
  - 3: alternating pattern. First word is {DATA_W/2{2'b01}}, e.g. 0x55; each following word is its bitwise inverse.
- States:
  - IDLE: waits for `newRxData` = 1, then goes to LOAD.
  - LOAD: latches `cmd`, `N` and `mode`; clears `sent` and the pattern counter; clears the gap counter; goes to GAP.
  - GAP: gap counter increments each cycle. Stays in GAP for exactly DLY_CYCLES cycles, then goes to WAIT_TX.
  - WAIT_TX: stays while `txBusy` = 1. When `txBusy` = 0, loads `odata` with the mode word and goes to EMIT.
  - EMIT: `oe` = 1 for this cycle only; `sent` increments. If `sent + 1 < N`, clears the gap counter, advances the pattern and goes to GAP. Otherwise goes to DONE.
  - DONE: `done` = 1 for this cycle; goes to IDLE.
- `newRxData` in any state other than IDLE is ignored. It is not queued.
- `txBusy` is examined only in WAIT_TX. A `txBusy` change during GAP has no effect.
- `odata` holds its last value between strobes and after DONE.
- Unused state encodings recover to IDLE on the next clock.

## Timing
- Reset values: `odata` = 0, `oe` = 0, `busy` = 0, `done` = 0, state = IDLE, all counters 0. Reset takes effect immediately, asynchronously.
- Reset mid-burst: the burst is aborted with no further `oe`. After reset deassertion the block sits in IDLE and needs a new command.
- First word latency: let edge E sample `newRxData` = 1 with `txBusy` = 0. `oe` is high during the cycle starting at edge E + DLY_CYCLES + 3.
  - 1 cycle LOAD, DLY_CYCLES cycles GAP, 1 cycle WAIT_TX, then EMIT.
- With `txBusy` held low, consecutive `oe` strobes are spaced DLY_CYCLES + 2 cycles apart.
- Each cycle `txBusy` stays high in WAIT_TX adds one cycle before EMIT.
- `done` is high the cycle after the last `oe`. `busy` falls on the same edge that `done` falls.
- `busy` rises on the edge after E.
- A new command is accepted in the first IDLE cycle after DONE.

## Test plan
Bench parameters: `DLY_CYCLES` = 4, `DATA_W` = 8.
1. Reset: assert `rst` mid-GAP of a 10-word burst → `oe`/`busy`/`done`/`odata` go to 0 immediately; no `oe` after release until a new command.
2. Mode 1, N = 3: cmd 0x42 with `txBusy` = 0 → `oe` at E+7, E+13, E+19 with `odata` 0x00, 0x01, 0x02; `done` at E+20.
3. Mode 0, N = 1: cmd 0x00, `testdata` = 0xA5 held → single `oe` with `odata` = 0xA5 at E+7; `done` at E+8.
4. `txBusy` stall: cmd 0xC1 (mode 3, N = 2), `txBusy` high for 5 cycles after entering WAIT_TX → first `oe` delayed by 5 cycles; `odata` 0x55 then 0xAA.
5. Ignored command: cmd 0x80 (echo, N = 1); pulse `newRxData` with 0x3F during GAP → exactly one `oe` with `odata` = 0x80.
6. Max length and wrap: cmd 0x7F (mode 1, N = 64) → exactly 64 `oe` strobes, values 0..63; `done` once. Repeat with `DATA_W` = 4 → counter wraps 0xF→0x0.
